// File: rtl/vx_tex_texel_fetch_pkg.sv
// Texture unit shared types: widths, texel index and fetch FSM states.
package vx_tex_texel_fetch_pkg;
  localparam int TEX_ADDR_BITS     = 26;
  localparam int TEX_FILTER_BITS   = 1;
  localparam int TEX_LGSTRIDE_BITS = 2;
  localparam int TEX_BLEND_FRAC    = 8;
  localparam int NUM_TEXELS        = 4;

  typedef logic [1:0] texel_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DONE
  } fetch_state_t;
endpackage

// File: rtl/vx_tex_texel_align.sv
// Per-lane texel extract: picks a byte, halfword or word out of a
// fetched memory word using the texel stride and byte offset.
module vx_tex_texel_align
  import vx_tex_texel_fetch_pkg::*;
(
  input  logic [TEX_LGSTRIDE_BITS-1:0] lgstride,
  input  logic [1:0]                   offset,
  input  logic [31:0]                  data,
  output logic [31:0]                  texel
);
  always_comb begin
    texel = data;
    unique case (lgstride)
      TEX_LGSTRIDE_BITS'(0):
        texel = {24'b0, data[{offset, 3'b000} +: 8]};
      TEX_LGSTRIDE_BITS'(1):
        texel = {16'b0, data[{offset[1], 4'b0000} +: 16]};
      default:
        texel = data;
    endcase
  end
endmodule

// File: rtl/vx_tex_texel_fetch.sv
// Texel fetch: issues 1 or 4 lane-parallel word reads per packet,
// gathers out-of-order responses by tag, then hands texels onward.
module vx_tex_texel_fetch
  import vx_tex_texel_fetch_pkg::*;
#(
  parameter string INSTANCE_ID = "",
  parameter int    REQ_INFOW   = 1,
  parameter int    NUM_LANES   = 1,
  parameter int    W_ADDR_BITS = TEX_ADDR_BITS + 6
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  input  logic [NUM_LANES-1:0]                  req_mask,
  input  logic [TEX_FILTER_BITS-1:0]            req_filter,
  input  logic [TEX_LGSTRIDE_BITS-1:0]          req_lgstride,
  input  logic [NUM_LANES*W_ADDR_BITS-1:0]      req_baseaddr,
  input  logic [NUM_LANES*NUM_TEXELS*32-1:0]    req_addr,
  input  logic [NUM_LANES*2*TEX_BLEND_FRAC-1:0] req_blends,
  input  logic [REQ_INFOW-1:0]                  req_info,
  output logic                                  req_ready,
  output logic                                  mem_req_valid,
  output logic [NUM_LANES-1:0]                  mem_req_mask,
  output logic [NUM_LANES*(W_ADDR_BITS-2)-1:0]  mem_req_addr,
  output logic [1:0]                            mem_req_tag,
  input  logic                                  mem_req_ready,
  input  logic                                  mem_rsp_valid,
  input  logic [NUM_LANES*32-1:0]               mem_rsp_data,
  input  logic [1:0]                            mem_rsp_tag,
  output logic                                  mem_rsp_ready,
  output logic                                  rsp_valid,
  output logic [NUM_LANES-1:0]                  rsp_mask,
  output logic [NUM_LANES*NUM_TEXELS*32-1:0]    rsp_texels,
  output logic [NUM_LANES*2*TEX_BLEND_FRAC-1:0] rsp_blends,
  output logic [REQ_INFOW-1:0]                  rsp_info,
  input  logic                                  rsp_ready
);
  localparam int WA  = W_ADDR_BITS;
  localparam int BLW = NUM_LANES * 2 * TEX_BLEND_FRAC;

  fetch_state_t state, state_n;

  logic [2:0]                   issue_cnt;
  logic [2:0]                   recv_cnt;
  logic [2:0]                   recv_nxt;
  logic [2:0]                   num_q;
  logic                         bilin_q;
  logic [TEX_LGSTRIDE_BITS-1:0] lgstride_q;
  logic [NUM_LANES-1:0]         mask_q;
  logic [BLW-1:0]               blends_q;
  logic [REQ_INFOW-1:0]         info_q;
  logic [NUM_TEXELS-1:0]        seen_q;
  logic [WA-1:0]                base_q  [NUM_LANES];
  logic [31:0]                  addr_q  [NUM_LANES][NUM_TEXELS];
  logic [31:0]                  texel_q [NUM_LANES][NUM_TEXELS];
  logic [31:0]                  aligned [NUM_LANES];

  logic       req_fire;
  logic       issue_fire;
  logic       recv_fire;
  texel_idx_t req_tag;
  texel_idx_t rsp_tag;

  assign req_tag    = issue_cnt[1:0];
  assign rsp_tag    = mem_rsp_tag;
  assign req_fire   = req_ready & req_valid;
  assign issue_fire = mem_req_valid & mem_req_ready;
  assign recv_fire  = mem_rsp_valid & mem_rsp_ready;
  assign recv_nxt   = recv_cnt + {2'b00, recv_fire};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_n = (req_mask != '0) ? ST_FETCH : ST_DONE;
      end
      ST_FETCH: begin
        mem_rsp_ready = 1'b1;
        mem_req_valid = (issue_cnt < num_q);
        if (recv_nxt == num_q) state_n = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      num_q      <= '0;
      bilin_q    <= 1'b0;
      lgstride_q <= '0;
      mask_q     <= '0;
      blends_q   <= '0;
      info_q     <= '0;
      seen_q     <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        base_q[i] <= '0;
        for (int t = 0; t < NUM_TEXELS; t++) begin
          addr_q[i][t]  <= '0;
          texel_q[i][t] <= '0;
        end
      end
    end else begin
      if (req_fire) begin
        issue_cnt  <= '0;
        recv_cnt   <= '0;
        seen_q     <= '0;
        bilin_q    <= (req_filter != '0);
        num_q      <= (req_filter != '0) ? 3'd4 : 3'd1;
        lgstride_q <= req_lgstride;
        mask_q     <= req_mask;
        blends_q   <= req_blends;
        info_q     <= req_info;
        for (int i = 0; i < NUM_LANES; i++) begin
          base_q[i] <= req_baseaddr[i*WA +: WA];
          for (int t = 0; t < NUM_TEXELS; t++) begin
            addr_q[i][t]  <= req_addr[(i*NUM_TEXELS+t)*32 +: 32];
            texel_q[i][t] <= '0;
          end
        end
      end
      if (issue_fire) issue_cnt <= issue_cnt + 3'd1;
      if (recv_fire) begin
        recv_cnt        <= recv_nxt;
        seen_q[rsp_tag] <= 1'b1;
        for (int i = 0; i < NUM_LANES; i++)
          texel_q[i][rsp_tag] <= aligned[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [WA-1:0] sum;
    logic [1:0]    unused_sum_lsb;
    // Byte address wraps at WA bits before dropping to a word address.
    assign sum            = base_q[i] + WA'(addr_q[i][req_tag]);
    assign unused_sum_lsb = sum[1:0];
    assign mem_req_addr[i*(WA-2) +: WA-2] = sum[WA-1:2];

    vx_tex_texel_align u_align (
      .lgstride (lgstride_q),
      .offset   (addr_q[i][rsp_tag][1:0]),
      .data     (mem_rsp_data[i*32 +: 32]),
      .texel    (aligned[i])
    );

    for (genvar t = 0; t < NUM_TEXELS; t++) begin : g_tex
      assign rsp_texels[(i*NUM_TEXELS+t)*32 +: 32] =
        bilin_q ? texel_q[i][t] : texel_q[i][0];
    end
  end

  assign mem_req_tag  = req_tag;
  assign mem_req_mask = mask_q;
  assign rsp_mask     = mask_q;
  assign rsp_blends   = blends_q;
  assign rsp_info     = info_q;

  always_ff @(posedge clk) begin
    if (!reset && mem_rsp_valid) begin
      assert (state == ST_FETCH)
        else $error("%s: memory response outside fetch", INSTANCE_ID);
      assert (state != ST_FETCH || !seen_q[rsp_tag])
        else $error("%s: duplicate texel tag %0d", INSTANCE_ID, rsp_tag);
    end
  end
endmodule

// File: tb/tb_vx_tex_texel_fetch.sv
// Randomized bench for vx_tex_texel_fetch with an out-of-order
// memory model and a reference texel model.
module tb_vx_tex_texel_fetch;
  import vx_tex_texel_fetch_pkg::*;

  localparam int NL  = 2;
  localparam int IW  = 4;
  localparam int WA  = 32;
  localparam int BLW = NL * 2 * TEX_BLEND_FRAC;
  localparam int TXW = NL * NUM_TEXELS * 32;
  localparam int MAW = NL * (WA - 2);

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         req_valid = 1'b0;
  logic [NL-1:0]                req_mask = '0;
  logic [TEX_FILTER_BITS-1:0]   req_filter = '0;
  logic [TEX_LGSTRIDE_BITS-1:0] req_lgstride = '0;
  logic [NL*WA-1:0]             req_baseaddr = '0;
  logic [TXW-1:0]               req_addr = '0;
  logic [BLW-1:0]               req_blends = '0;
  logic [IW-1:0]                req_info = '0;
  logic                         req_ready;
  logic                         mem_req_valid;
  logic [NL-1:0]                mem_req_mask;
  logic [MAW-1:0]               mem_req_addr;
  logic [1:0]                   mem_req_tag;
  logic                         mem_req_ready = 1'b0;
  logic                         mem_rsp_valid = 1'b0;
  logic [NL*32-1:0]             mem_rsp_data = '0;
  logic [1:0]                   mem_rsp_tag = '0;
  logic                         mem_rsp_ready;
  logic                         rsp_valid;
  logic [NL-1:0]                rsp_mask;
  logic [TXW-1:0]               rsp_texels;
  logic [BLW-1:0]               rsp_blends;
  logic [IW-1:0]                rsp_info;
  logic                         rsp_ready = 1'b0;

  vx_tex_texel_fetch #(
    .INSTANCE_ID ("tb"),
    .REQ_INFOW   (IW),
    .NUM_LANES   (NL),
    .W_ADDR_BITS (WA)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_mask      (req_mask),
    .req_filter    (req_filter),
    .req_lgstride  (req_lgstride),
    .req_baseaddr  (req_baseaddr),
    .req_addr      (req_addr),
    .req_blends    (req_blends),
    .req_info      (req_info),
    .req_ready     (req_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_mask  (mem_req_mask),
    .mem_req_addr  (mem_req_addr),
    .mem_req_tag   (mem_req_tag),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_tag   (mem_rsp_tag),
    .mem_rsp_ready (mem_rsp_ready),
    .rsp_valid     (rsp_valid),
    .rsp_mask      (rsp_mask),
    .rsp_texels    (rsp_texels),
    .rsp_blends    (rsp_blends),
    .rsp_info      (rsp_info),
    .rsp_ready     (rsp_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // packet under test
  logic [31:0]    p_base [NL];
  logic [31:0]    p_addr [NL][4];
  logic [NL-1:0]  p_mask;
  logic           p_bilin;
  logic [1:0]     p_lgs;
  logic [BLW-1:0] p_blends;
  logic [IW-1:0]  p_info;
  logic           use_fixed = 1'b0;
  logic [31:0]    fixed_word = '0;
  int             order_q[$];
  int             stall_req = 0;
  int             stall_rsp = 0;
  int             cut_issue = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] wa);
    if (use_fixed) return fixed_word;
    return wa * 32'h9E3779B1 + 32'h7F4A7C15;
  endfunction

  function automatic logic [31:0] waddr(input int l, input int t);
    logic [31:0] s;
    s = p_base[l] + p_addr[l][t];
    return s >> 2;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input int off, input int lgs);
    if (lgs == 0) return (w >> (8 * off)) & 32'hFF;
    if (lgs == 1) return (w >> (16 * (off / 2))) & 32'hFFFF;
    return w;
  endfunction

  function automatic logic [MAW-1:0] exp_maddr(input int t);
    logic [MAW-1:0] v;
    logic [31:0]    s;
    v = '0;
    for (int l = 0; l < NL; l++) begin
      s = waddr(l, t);
      v[l*(WA-2) +: WA-2] = s[WA-3:0];
    end
    return v;
  endfunction

  function automatic logic [NL*32-1:0] rsp_data(input int t);
    logic [NL*32-1:0] v;
    v = '0;
    for (int l = 0; l < NL; l++)
      if (p_mask[l]) v[l*32 +: 32] = memw(waddr(l, t));
    return v;
  endfunction

  function automatic logic [TXW-1:0] exp_texels();
    logic [TXW-1:0] v;
    logic [31:0]    a;
    int             ts;
    v = '0;
    for (int l = 0; l < NL; l++)
      for (int t = 0; t < 4; t++) begin
        ts = p_bilin ? t : 0;
        a  = p_addr[l][ts];
        if (p_mask[l])
          v[(l*4+t)*32 +: 32] =
            extract(memw(waddr(l, ts)), int'(a[1:0]), int'(p_lgs));
      end
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_pkt();
    p_bilin  = 1'($urandom_range(1, 0));
    p_lgs    = 2'($urandom_range(3, 0));
    p_mask   = NL'($urandom_range(3, 0));
    p_blends = BLW'($urandom);
    p_info   = IW'($urandom);
    for (int l = 0; l < NL; l++) begin
      p_base[l] = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : $urandom;
      for (int t = 0; t < 4; t++) p_addr[l][t] = $urandom;
    end
  endtask

  task automatic run_pkt(input string name);
    int n, issued, cyc, last_rsp, done_cyc, stall, k;
    int pend[$];
    bit bad_ready, bad_req, bad_rrdy;
    logic [TXW-1:0] exp_tx;
    n = (p_mask == '0) ? 0 : (p_bilin ? 4 : 1);
    issued = 0; cyc = 0; last_rsp = -1; done_cyc = -1;
    stall = stall_req;
    bad_ready = 0; bad_req = 0; bad_rrdy = 0;
    chk({name, ".req_ready"}, req_ready, 1'b1);
    req_valid    = 1'b1;
    req_mask     = p_mask;
    req_filter   = p_bilin;
    req_lgstride = p_lgs;
    req_blends   = p_blends;
    req_info     = p_info;
    for (int l = 0; l < NL; l++) begin
      req_baseaddr[l*WA +: WA] = p_base[l];
      for (int t = 0; t < 4; t++) req_addr[(l*4+t)*32 +: 32] = p_addr[l][t];
    end
    @(negedge clk);
    // scramble inputs so only latched values can produce the result
    req_valid = 1'b0;
    req_mask = NL'($urandom);
    req_lgstride = 2'($urandom);
    req_blends = BLW'($urandom);
    req_baseaddr = {$urandom, $urandom};
    for (int w = 0; w < 8; w++) req_addr[w*32 +: 32] = $urandom;
    while (cyc < 200) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (rsp_valid) begin done_cyc = cyc; break; end
      if (req_ready) bad_ready = 1;
      if (cut_issue > 0 && issued == cut_issue) break;
      k = -1;
      if (pend.size() > 0) begin
        if (order_q.size() > 0) begin
          foreach (pend[j]) if (pend[j] == order_q[0]) k = j;
          if (k >= 0) void'(order_q.pop_front());
        end else if ($urandom_range(1, 0) == 1) begin
          k = int'($urandom_range(pend.size() - 1, 0));
        end
      end
      if (k >= 0) begin
        if (!mem_rsp_ready) bad_rrdy = 1;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'(pend[k]);
        mem_rsp_data  = rsp_data(pend[k]);
        pend.delete(k);
        last_rsp = cyc;
      end
      if (mem_req_valid) begin
        if (issued >= n || mem_req_tag !== 2'(issued) ||
            mem_req_mask !== p_mask || mem_req_addr !== exp_maddr(issued))
          bad_req = 1;
        if (stall > 0) stall--;
        else if (issued < n) begin
          mem_req_ready = 1'b1;
          pend.push_back(issued);
          issued++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    chk({name, ".memreq"}, bad_req, 1'b0);
    chk({name, ".busy_ready"}, bad_ready, 1'b0);
    if (cut_issue > 0) begin
      chk({name, ".cut"}, issued, cut_issue);
      return;
    end
    chk({name, ".done"}, done_cyc >= 0, 1'b1);
    chk({name, ".issued"}, issued, n);
    chk({name, ".mem_rsp_ready"}, bad_rrdy, 1'b0);
    if (done_cyc < 0) begin
      do_reset();
      return;
    end
    chk({name, ".latency"}, done_cyc - last_rsp, 1);
    exp_tx = exp_texels();
    for (int h = 0; h <= stall_rsp; h++) begin
      chk({name, ".hold"}, {rsp_valid, req_ready}, 2'b10);
      chk({name, ".texels"}, rsp_texels, exp_tx);
      chk({name, ".mask"}, rsp_mask, p_mask);
      chk({name, ".blends"}, rsp_blends, p_blends);
      chk({name, ".info"}, rsp_info, p_info);
      if (h < stall_rsp) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, ".release"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset.ctrl", {req_ready, mem_req_valid, mem_rsp_ready, rsp_valid},
        4'b1000);
    chk("reset.texels", rsp_texels, '0);
    chk("reset.data", {mem_req_addr, mem_req_tag, mem_req_mask, rsp_mask,
                       rsp_blends, rsp_info}, '0);
    reset = 1'b0;

    // point fetch, word stride
    rand_pkt();
    p_bilin = 1'b0; p_lgs = 2'd2; p_mask = 2'b01;
    p_base[0] = 32'h1000; p_addr[0][0] = 32'h10;
    use_fixed = 1'b1; fixed_word = 32'hAABBCCDD;
    chk("t1.waddr", waddr(0, 0), 32'h404);
    run_pkt("t1");

    // bilinear bytes
    rand_pkt();
    p_bilin = 1'b1; p_lgs = 2'd0; p_mask = 2'b11;
    fixed_word = 32'h44332211;
    for (int l = 0; l < NL; l++) begin
      p_base[l] = 32'h2000;
      p_addr[l][0] = 32'h1; p_addr[l][1] = 32'h2;
      p_addr[l][2] = 32'h3; p_addr[l][3] = 32'h0;
    end
    run_pkt("t2");
    chk("t2.slot1", rsp_texels[63:32], 32'h33);
    use_fixed = 1'b0;

    // out-of-order return with wrapping base
    rand_pkt();
    p_bilin = 1'b1; p_lgs = 2'd1; p_mask = 2'b11;
    p_base[0] = 32'hFFFF_FFF8;
    order_q = '{3, 1, 0, 2};
    run_pkt("t3");
    chk("t3.order_used", order_q.size(), 0);

    // empty mask
    rand_pkt();
    p_bilin = 1'b1; p_mask = 2'b00;
    run_pkt("t4");

    // backpressure on both sides
    rand_pkt();
    p_bilin = 1'b1; p_mask = 2'b10;
    stall_req = 5; stall_rsp = 3;
    run_pkt("t5");
    stall_req = 0; stall_rsp = 0;

    // reset in the middle of a fetch
    rand_pkt();
    p_bilin = 1'b1; p_mask = 2'b11;
    cut_issue = 2;
    run_pkt("t6");
    cut_issue = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("t6.idle", {req_ready, rsp_valid, mem_req_valid, mem_rsp_ready},
        4'b1000);
    reset = 1'b0;
    rand_pkt();
    p_mask = 2'b11;
    run_pkt("t6.after");

    for (int i = 0; i < 40; i++) begin
      rand_pkt();
      stall_req = $urandom_range(2, 0);
      stall_rsp = $urandom_range(2, 0);
      run_pkt($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
